// File: rtl/sdram_port_scheduler.sv
// Three-port SDRAM front-end: arbitrates video bursts against CPU/DMA single-word
// traffic, with round-robin between CPU and DMA and a starvation override for video.
module sdram_port_scheduler #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_x16_i,
  input  logic [15:0]       cpu_wdata_i,
  input  logic [1:0]        cpu_wmask_i,
  output logic              cpu_ack_o,
  output logic              cpu_rdy_o,
  output logic [15:0]       cpu_rdata_o,

  input  logic              dma_rd_i,
  input  logic              dma_wr_i,
  input  logic [ADDR_W-1:0] dma_addr_x16_i,
  input  logic [15:0]       dma_wdata_i,
  input  logic [1:0]        dma_wmask_i,
  output logic              dma_ack_o,
  output logic              dma_rdy_o,
  output logic [15:0]       dma_rdata_o,

  input  logic              vid_rd_i,
  input  logic [ADDR_W-1:0] vid_addr_x16_i,
  output logic              vid_ack_o,
  output logic              vid_rdy_o,
  output logic [15:0]       vid_rdata_o,

  output logic              sdram_rd_o,
  output logic              sdram_wr_o,
  output logic [ADDR_W-1:0] sdram_addr_x16_o,
  output logic [15:0]       sdram_wdata_o,
  output logic [1:0]        sdram_wmask_o,
  output logic              sdram_burst_o,
  input  logic              sdram_ack_i,
  input  logic              sdram_rdy_i,
  input  logic [15:0]       sdram_rdata_i,

  output logic [1:0]        grant_o
);

  localparam int unsigned BeatW   = $clog2(BURST_LEN + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntVid  = 2'd1;
  localparam logic [1:0] GntCpu  = 2'd2;
  localparam logic [1:0] GntDma  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

  state_e              state_q;
  logic [1:0]          grant_q;
  logic                cmd_rd_q;
  logic                cmd_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [1:0]          wmask_q;
  logic                burst_q;
  logic [BeatW-1:0]    beats_q;
  logic [StarveW-1:0]  starve_q;
  logic [StarveW-1:0]  starve_d;
  logic                prefer_dma_q;

  logic                cpu_req;
  logic                dma_req;
  logic                vid_req;
  logic                starve_full;
  logic                starve_inc;
  logic [1:0]          win;
  logic                win_rd;
  logic [ADDR_W-1:0]   win_addr;
  logic [15:0]         win_wdata;
  logic [1:0]          win_wmask;
  logic [BeatW-1:0]    beat_target;
  logic [BeatW-1:0]    beat_next;
  logic                rdy_live;
  logic                last_beat;

  assign cpu_req     = cpu_rd_i | cpu_wr_i;
  assign dma_req     = dma_rd_i | dma_wr_i;
  assign vid_req     = vid_rd_i;
  assign starve_full = (starve_q == StarveW'(STARVE_MAX));

  // Video wins unless a starved CPU/DMA request is waiting; rd+wr together counts as a read.
  always_comb begin
    win       = GntNone;
    win_rd    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wmask = '0;
    if (vid_req && !(starve_full && (cpu_req || dma_req))) begin
      win      = GntVid;
      win_rd   = 1'b1;
      win_addr = vid_addr_x16_i;
    end else if (cpu_req && (!dma_req || !prefer_dma_q)) begin
      win       = GntCpu;
      win_rd    = cpu_rd_i;
      win_addr  = cpu_addr_x16_i;
      win_wdata = cpu_wdata_i;
      win_wmask = cpu_wmask_i;
    end else if (dma_req) begin
      win       = GntDma;
      win_rd    = dma_rd_i;
      win_addr  = dma_addr_x16_i;
      win_wdata = dma_wdata_i;
      win_wmask = dma_wmask_i;
    end
  end

  always_comb begin
    if (state_q == StIdle) begin
      starve_inc = (win == GntVid) && (cpu_req || dma_req);
    end else begin
      starve_inc = (cpu_req && (grant_q != GntCpu)) || (dma_req && (grant_q != GntDma));
    end
    starve_d = starve_q;
    if ((state_q == StIdle) && ((win == GntCpu) || (win == GntDma))) begin
      starve_d = '0;
    end else if (starve_inc && !starve_full) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // A read word can already arrive in the cycle the command is accepted.
  assign rdy_live    = sdram_rdy_i & ((state_q == StRdWait) |
                                      ((state_q == StIssue) & sdram_ack_i & cmd_rd_q));
  assign beat_target = (grant_q == GntVid) ? BeatW'(BURST_LEN) : BeatW'(1);
  assign beat_next   = beats_q + BeatW'(1);
  assign last_beat   = rdy_live && (beat_next == beat_target);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      grant_q      <= GntNone;
      cmd_rd_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      burst_q      <= 1'b0;
      beats_q      <= '0;
      starve_q     <= '0;
      prefer_dma_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      unique case (state_q)
        StIdle: begin
          if (win != GntNone) begin
            state_q  <= StIssue;
            grant_q  <= win;
            cmd_rd_q <= win_rd;
            cmd_wr_q <= !win_rd;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            wmask_q  <= win_wmask;
            burst_q  <= (win == GntVid);
            beats_q  <= '0;
            if (win == GntCpu) prefer_dma_q <= 1'b1;
            if (win == GntDma) prefer_dma_q <= 1'b0;
          end
        end
        StIssue: begin
          if (sdram_ack_i) begin
            cmd_rd_q <= 1'b0;
            cmd_wr_q <= 1'b0;
            if (cmd_wr_q || last_beat) begin
              state_q <= StIdle;
              grant_q <= GntNone;
              burst_q <= 1'b0;
              beats_q <= '0;
            end else begin
              state_q <= StRdWait;
              beats_q <= rdy_live ? BeatW'(1) : '0;
            end
          end
        end
        StRdWait: begin
          if (last_beat) begin
            state_q <= StIdle;
            grant_q <= GntNone;
            burst_q <= 1'b0;
            beats_q <= '0;
          end else if (rdy_live) begin
            beats_q <= beat_next;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= GntNone;
        end
      endcase
    end
  end

  assign sdram_rd_o       = cmd_rd_q;
  assign sdram_wr_o       = cmd_wr_q;
  assign sdram_addr_x16_o = addr_q;
  assign sdram_wdata_o    = wdata_q;
  assign sdram_wmask_o    = wmask_q;
  assign sdram_burst_o    = burst_q;
  assign grant_o          = grant_q;

  assign vid_ack_o = sdram_ack_i & (grant_q == GntVid);
  assign cpu_ack_o = sdram_ack_i & (grant_q == GntCpu);
  assign dma_ack_o = sdram_ack_i & (grant_q == GntDma);

  assign vid_rdy_o = rdy_live & (grant_q == GntVid);
  assign cpu_rdy_o = rdy_live & (grant_q == GntCpu);
  assign dma_rdy_o = rdy_live & (grant_q == GntDma);

  assign vid_rdata_o = sdram_rdata_i;
  assign cpu_rdata_o = sdram_rdata_i;
  assign dma_rdata_o = sdram_rdata_i;

endmodule
